// File: rtl/bp_cfg_loader_pkg.sv
// Shared types for the boot-time config loader: register map, FSM states, command payload.
// Optional feature macro: BP_CFG_LOADER_READBACK_EN (adds the e_readback state).
package bp_cfg_loader_pkg;

  localparam int unsigned cmd_core_width_lp = 8;
  localparam int unsigned cmd_data_width_lp = 32;

  typedef enum logic [1:0] {
    e_cfg_freeze      = 2'd0,
    e_cfg_core_id     = 2'd1,
    e_cfg_cce_mode    = 2'd2,
    e_cfg_icache_mode = 2'd3
  } bp_cfg_reg_e;

  typedef enum logic [2:0] {
    e_reset    = 3'd0,
    e_freeze   = 3'd1,
    e_program  = 3'd2,
    e_unfreeze = 3'd3,
    e_done     = 3'd4
`ifdef BP_CFG_LOADER_READBACK_EN
    , e_readback = 3'd5
`endif
  } bp_cfg_loader_state_e;

  // Widest-case payload; the top trims core/data to its parameterised port widths.
  typedef struct packed {
    logic                         w;
    logic [cmd_core_width_lp-1:0] core;
    bp_cfg_reg_e                  addr;
    logic [cmd_data_width_lp-1:0] data;
  } bp_cfg_cmd_s;

  // Programming-phase register index 0..2 maps onto core_id, cce_mode, icache_mode.
  function automatic bp_cfg_reg_e program_reg(input logic [1:0] idx);
    return bp_cfg_reg_e'(idx + 2'd1);
  endfunction

endpackage

// File: rtl/bp_cfg_loader_cmd_gen.sv
// Combinational config command generator: FSM state + counters -> command payload.
// Optional feature macro: BP_CFG_LOADER_READBACK_EN (read-back commands in the program phase).
module bp_cfg_loader_cmd_gen
  import bp_cfg_loader_pkg::*;
#(
  parameter int unsigned cnt_width_p   = 1,
  parameter int unsigned cce_mode_p    = 0,
  parameter int unsigned icache_mode_p = 0
) (
  input  bp_cfg_loader_state_e   state_i,
  input  logic [cnt_width_p-1:0] core_cnt_i,
  input  logic [1:0]             reg_cnt_i,
  input  logic                   read_i,
  output bp_cfg_cmd_s            cmd_o
);

  // Decode the command for the current phase; idle states present all zeros.
  always_comb begin
    cmd_o = '0;
    case (state_i)
      e_freeze: begin
        cmd_o.w    = 1'b1;
        cmd_o.core = cmd_core_width_lp'(core_cnt_i);
        cmd_o.addr = e_cfg_freeze;
        cmd_o.data = cmd_data_width_lp'(1);
      end
`ifdef BP_CFG_LOADER_READBACK_EN
      e_program, e_readback: begin
`else
      e_program: begin
`endif
        cmd_o.w    = ~read_i;
        cmd_o.core = cmd_core_width_lp'(core_cnt_i);
        cmd_o.addr = program_reg(reg_cnt_i);
        case (program_reg(reg_cnt_i))
          e_cfg_core_id:     cmd_o.data = cmd_data_width_lp'(core_cnt_i);
          e_cfg_cce_mode:    cmd_o.data = cmd_data_width_lp'(cce_mode_p);
          e_cfg_icache_mode: cmd_o.data = cmd_data_width_lp'(icache_mode_p);
          default:           cmd_o.data = '0;
        endcase
      end
      e_unfreeze: begin
        cmd_o.w    = 1'b1;
        cmd_o.core = cmd_core_width_lp'(core_cnt_i);
        cmd_o.addr = e_cfg_freeze;
        cmd_o.data = '0;
      end
      default: cmd_o = '0;
    endcase
  end

endmodule

// File: rtl/bp_cfg_loader.sv
// Boot-time config sequencer: freeze all cores, program id/cce/icache modes, unfreeze.
// Optional feature macro: BP_CFG_LOADER_READBACK_EN (read back each programmed register, flag mismatches).
module bp_cfg_loader
  import bp_cfg_loader_pkg::*;
#(
  parameter int unsigned num_core_p       = 1,
  parameter int unsigned cfg_addr_width_p = 8,
  parameter int unsigned cfg_data_width_p = 16,
  parameter int unsigned cce_mode_p       = 0,
  parameter int unsigned icache_mode_p    = 0,
  localparam int unsigned core_width_lp   = (num_core_p > 1) ? $clog2(num_core_p) : 1,
  localparam int unsigned cnt_width_lp    = $clog2(num_core_p) + 1
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  output logic                        cfg_v_o,
  output logic                        cfg_w_o,
  output logic [core_width_lp-1:0]    cfg_core_o,
  output logic [cfg_addr_width_p-1:0] cfg_addr_o,
  output logic [cfg_data_width_p-1:0] cfg_data_o,
  input  logic                        cfg_ready_i,
  output logic                        freeze_o,
  output logic                        done_o
`ifdef BP_CFG_LOADER_READBACK_EN
  , input  logic                        cfg_rdata_v_i
  , input  logic [cfg_data_width_p-1:0] cfg_rdata_i
  , output logic                        err_o
`endif
);

  bp_cfg_loader_state_e    state_r, state_n;
  logic [cnt_width_lp-1:0] core_cnt_r, core_cnt_n;
  logic [1:0]              reg_cnt_r, reg_cnt_n;
  logic                    hs, last_core, last_reg, prog_step, rd_phase;
  bp_cfg_cmd_s             cmd;
  logic                    unused_cmd_bits;

`ifdef BP_CFG_LOADER_READBACK_EN
  logic rd_phase_r, rd_phase_n;
  logic err_r, err_n;
  assign rd_phase = rd_phase_r;
  assign err_o    = err_r;
`else
  assign rd_phase = 1'b0;
`endif

  assign hs        = cfg_v_o & cfg_ready_i;
  assign last_core = (core_cnt_r == cnt_width_lp'(num_core_p - 1));
  assign last_reg  = (reg_cnt_r == 2'd2);

  bp_cfg_loader_cmd_gen #(
    .cnt_width_p   (cnt_width_lp),
    .cce_mode_p    (cce_mode_p),
    .icache_mode_p (icache_mode_p)
  ) u_cmd_gen (
    .state_i    (state_r),
    .core_cnt_i (core_cnt_r),
    .reg_cnt_i  (reg_cnt_r),
    .read_i     (rd_phase),
    .cmd_o      (cmd)
  );

  // Command presentation: valid in every issuing phase, fields follow the counters.
  assign cfg_v_o    = (state_r == e_freeze) | (state_r == e_program) | (state_r == e_unfreeze);
  assign cfg_w_o    = cmd.w;
  assign cfg_core_o = core_width_lp'(cmd.core);
  assign cfg_addr_o = cfg_addr_width_p'(cmd.addr);
  assign cfg_data_o = cfg_data_width_p'(cmd.data);
  assign freeze_o   = (state_r != e_done);
  assign done_o     = (state_r == e_done);

  assign unused_cmd_bits = ^{cmd.core, cmd.data};

  // Next-state and counter advance; counters move only when a command retires.
  always_comb begin
    state_n    = state_r;
    core_cnt_n = core_cnt_r;
    reg_cnt_n  = reg_cnt_r;
    prog_step  = 1'b0;
`ifdef BP_CFG_LOADER_READBACK_EN
    rd_phase_n = rd_phase_r;
    err_n      = err_r;
`endif
    case (state_r)
      e_reset: state_n = e_freeze;
      e_freeze: begin
        if (hs) begin
          if (last_core) begin
            core_cnt_n = '0;
            state_n    = e_program;
          end else begin
            core_cnt_n = core_cnt_r + cnt_width_lp'(1);
          end
        end
      end
      e_program: begin
`ifdef BP_CFG_LOADER_READBACK_EN
        if (hs) begin
          if (!rd_phase_r) begin
            rd_phase_n = 1'b1;
          end else begin
            rd_phase_n = 1'b0;
            state_n    = e_readback;
          end
        end
`else
        prog_step = hs;
`endif
      end
`ifdef BP_CFG_LOADER_READBACK_EN
      e_readback: begin
        if (cfg_rdata_v_i) begin
          prog_step = 1'b1;
          if (cfg_rdata_i != cfg_data_o) err_n = 1'b1;
        end
      end
`endif
      e_unfreeze: begin
        if (hs) begin
          if (last_core) begin
            core_cnt_n = '0;
            state_n    = e_done;
          end else begin
            core_cnt_n = core_cnt_r + cnt_width_lp'(1);
          end
        end
      end
      e_done:  state_n = e_done;
      default: state_n = e_reset;
    endcase

    if (prog_step) begin
      if (last_reg) begin
        reg_cnt_n = '0;
        if (last_core) core_cnt_n = '0;
        else           core_cnt_n = core_cnt_r + cnt_width_lp'(1);
      end else begin
        reg_cnt_n = reg_cnt_r + 2'd1;
      end
      state_n = (last_reg && last_core) ? e_unfreeze : e_program;
    end
  end

  // State and counter registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r    <= e_reset;
      core_cnt_r <= '0;
      reg_cnt_r  <= '0;
`ifdef BP_CFG_LOADER_READBACK_EN
      rd_phase_r <= 1'b0;
      err_r      <= 1'b0;
`endif
    end else begin
      state_r    <= state_n;
      core_cnt_r <= core_cnt_n;
      reg_cnt_r  <= reg_cnt_n;
`ifdef BP_CFG_LOADER_READBACK_EN
      rd_phase_r <= rd_phase_n;
      err_r      <= err_n;
`endif
    end
  end

endmodule

// File: tb/tb_bp_cfg_loader.sv
// Self-checking bench for bp_cfg_loader: two instances (N=4 and N=1) against a command-list model.
// Optional feature macro: BP_CFG_LOADER_READBACK_EN (bench also models read-back and err_o).
module tb_bp_cfg_loader;

  typedef struct {
    bit w;
    int core;
    int addr;
    int data;
  } cmd_t;

  logic       clk;
  logic       reset;
  logic       rdy  [2];
  logic       v    [2];
  logic       w    [2];
  logic       frz  [2];
  logic       dn   [2];
  logic [7:0] adr  [2];
  logic [15:0] dat [2];
  logic [1:0] core0;
  logic [0:0] core1;
`ifdef BP_CFG_LOADER_READBACK_EN
  logic        rdv [2];
  logic [15:0] rdd [2];
  logic        err [2];
`endif

  bp_cfg_loader #(.num_core_p(4), .cfg_addr_width_p(8), .cfg_data_width_p(16),
                  .cce_mode_p(0), .icache_mode_p(1)) u_dut4 (
    .clk_i(clk), .reset_i(reset), .cfg_v_o(v[0]), .cfg_w_o(w[0]), .cfg_core_o(core0),
    .cfg_addr_o(adr[0]), .cfg_data_o(dat[0]), .cfg_ready_i(rdy[0]),
    .freeze_o(frz[0]), .done_o(dn[0])
`ifdef BP_CFG_LOADER_READBACK_EN
    , .cfg_rdata_v_i(rdv[0]), .cfg_rdata_i(rdd[0]), .err_o(err[0])
`endif
  );

  bp_cfg_loader #(.num_core_p(1), .cfg_addr_width_p(8), .cfg_data_width_p(16),
                  .cce_mode_p(1), .icache_mode_p(0)) u_dut1 (
    .clk_i(clk), .reset_i(reset), .cfg_v_o(v[1]), .cfg_w_o(w[1]), .cfg_core_o(core1),
    .cfg_addr_o(adr[1]), .cfg_data_o(dat[1]), .cfg_ready_i(rdy[1]),
    .freeze_o(frz[1]), .done_o(dn[1])
`ifdef BP_CFG_LOADER_READBACK_EN
    , .cfg_rdata_v_i(rdv[1]), .cfg_rdata_i(rdd[1]), .err_o(err[1])
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model state: expected command list per instance and progress through it.
  cmd_t exp_a [2][128];
  int   exp_len  [2];
  int   k        [2];
  bit   run_m    [2];
  bit   wait_m   [2];
  bit   err_m    [2];
  int   done_cyc [2];
  int   cyc;
  bit   log_en;
  cmd_t log1 [$];
  int   lit_addr [5];
  int   lit_data [5];
  int   vectors;
  int   miscompares;

  function automatic int cfg_n(input int i);      return (i == 0) ? 4 : 1; endfunction
  function automatic int cfg_cce(input int i);    return (i == 0) ? 0 : 1; endfunction
  function automatic int cfg_icache(input int i); return (i == 0) ? 1 : 0; endfunction

  function automatic void chk(input int i, input string name, input int act, input int expv);
    vectors++;
    if (act != expv) begin
      miscompares++;
      $display("FAIL inst%0d %s cyc=%0d: got %0d expected %0d", i, name, cyc, act, expv);
    end
  endfunction

  // Expected sequence straight from the register-write rules.
  function automatic void build(input int i);
    int len;
    int val;
    len = 0;
    for (int c = 0; c < cfg_n(i); c++) begin
      exp_a[i][len] = '{w: 1'b1, core: c, addr: 0, data: 1};
      len++;
    end
    for (int c = 0; c < cfg_n(i); c++) begin
      for (int r = 1; r <= 3; r++) begin
        val = (r == 1) ? c : (r == 2) ? cfg_cce(i) : cfg_icache(i);
        exp_a[i][len] = '{w: 1'b1, core: c, addr: r, data: val};
        len++;
`ifdef BP_CFG_LOADER_READBACK_EN
        exp_a[i][len] = '{w: 1'b0, core: c, addr: r, data: val};
        len++;
`endif
      end
    end
    for (int c = 0; c < cfg_n(i); c++) begin
      exp_a[i][len] = '{w: 1'b1, core: c, addr: 0, data: 0};
      len++;
    end
    exp_len[i] = len;
  endfunction

  function automatic void check_inst(input int i);
    int   core_act;
    cmd_t e;
    core_act = (i == 0) ? int'(core0) : int'(core1);
    if (!run_m[i]) begin
      chk(i, "rst_v",      int'(v[i]),   0);
      chk(i, "rst_w",      int'(w[i]),   0);
      chk(i, "rst_core",   core_act,     0);
      chk(i, "rst_addr",   int'(adr[i]), 0);
      chk(i, "rst_data",   int'(dat[i]), 0);
      chk(i, "rst_freeze", int'(frz[i]), 1);
      chk(i, "rst_done",   int'(dn[i]),  0);
    end else if (wait_m[i]) begin
      chk(i, "wait_v",      int'(v[i]),   0);
      chk(i, "wait_freeze", int'(frz[i]), 1);
      chk(i, "wait_done",   int'(dn[i]),  0);
    end else if (k[i] < exp_len[i]) begin
      e = exp_a[i][k[i]];
      chk(i, "v",      int'(v[i]),   1);
      chk(i, "w",      int'(w[i]),   int'(e.w));
      chk(i, "core",   core_act,     e.core);
      chk(i, "addr",   int'(adr[i]), e.addr);
      chk(i, "data",   int'(dat[i]), e.data & 32'hFFFF);
      chk(i, "freeze", int'(frz[i]), 1);
      chk(i, "done",   int'(dn[i]),  0);
    end else begin
      chk(i, "end_v",      int'(v[i]),   0);
      chk(i, "end_freeze", int'(frz[i]), 0);
      chk(i, "end_done",   int'(dn[i]),  1);
      if (done_cyc[i] < 0) done_cyc[i] = cyc;
    end
`ifdef BP_CFG_LOADER_READBACK_EN
    chk(i, "err", int'(err[i]), int'(err_m[i]));
`endif
  endfunction

  function automatic void update(input int i, input bit r);
    cmd_t a;
    if (r) begin
      run_m[i] = 1'b0; k[i] = 0; wait_m[i] = 1'b0; err_m[i] = 1'b0; done_cyc[i] = -1;
    end else if (!run_m[i]) begin
      run_m[i] = 1'b1; k[i] = 0;
      if (i == 0) cyc = 0;
    end else if (wait_m[i]) begin
`ifdef BP_CFG_LOADER_READBACK_EN
      if (rdv[i]) begin
        wait_m[i] = 1'b0;
        if (int'(rdd[i]) != (exp_a[i][k[i]-1].data & 32'hFFFF)) err_m[i] = 1'b1;
      end
`endif
    end else if (k[i] < exp_len[i] && rdy[i]) begin
      if (log_en && i == 1) begin
        a.w = w[1]; a.core = int'(core1); a.addr = int'(adr[1]); a.data = int'(dat[1]);
        log1.push_back(a);
      end
      if (!exp_a[i][k[i]].w) wait_m[i] = 1'b1;
      k[i]++;
    end
  endfunction

  // One clock: check outputs on the falling edge, then drive inputs for the next rising edge.
  task automatic step(input bit r, input bit r0, input bit r1);
    @(negedge clk);
    cyc++;
    check_inst(0);
    check_inst(1);
    reset  = r;
    rdy[0] = r0;
    rdy[1] = r1;
`ifdef BP_CFG_LOADER_READBACK_EN
    for (int i = 0; i < 2; i++) begin
      rdv[i] = wait_m[i] && ($urandom_range(0, 3) != 0);
      rdd[i] = '0;
      if (wait_m[i]) begin
        if (i == 0 && exp_a[i][k[i]-1].core == 1 && exp_a[i][k[i]-1].addr == 1) rdd[i] = 16'd0;
        else rdd[i] = 16'(exp_a[i][k[i]-1].data);
      end
    end
`endif
    update(0, r);
    update(1, r);
  endtask

  initial begin
    vectors = 0; miscompares = 0; cyc = 0; log_en = 1'b0;
    reset = 1'b1; rdy[0] = 1'b0; rdy[1] = 1'b0;
`ifdef BP_CFG_LOADER_READBACK_EN
    rdv[0] = 1'b0; rdv[1] = 1'b0; rdd[0] = '0; rdd[1] = '0;
`endif
    lit_addr = '{0, 1, 2, 3, 0};
    lit_data = '{1, 0, 1, 0, 0};
    for (int i = 0; i < 2; i++) begin
      build(i);
      run_m[i] = 1'b0; k[i] = 0; wait_m[i] = 1'b0; err_m[i] = 1'b0; done_cyc[i] = -1;
    end

    // Ready tied high: back-to-back commands.
    repeat (3) step(1'b1, 1'b1, 1'b1);
    log_en = 1'b1;
    repeat (30) step(1'b0, 1'b1, 1'b1);
    log_en = 1'b0;
`ifndef BP_CFG_LOADER_READBACK_EN
    chk(0, "a_done_cycle", done_cyc[0], 21);
    chk(1, "a_done_cycle", done_cyc[1], 6);
    chk(1, "a_log_len", log1.size(), 5);
    for (int j = 0; j < 5 && j < log1.size(); j++) begin
      chk(1, "a_log_w",    int'(log1[j].w), 1);
      chk(1, "a_log_core", log1[j].core,    0);
      chk(1, "a_log_addr", log1[j].addr,    lit_addr[j]);
      chk(1, "a_log_data", log1[j].data,    lit_data[j]);
    end
`endif

    // Ready toggling, low on odd cycles: every other cycle stalls.
    repeat (2) step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1);
    for (int j = 1; j <= 60; j++) step(1'b0, (j % 2) == 0, (j % 2) == 0);
`ifndef BP_CFG_LOADER_READBACK_EN
    chk(0, "b_done_cycle", done_cyc[0], 41);
    chk(1, "b_done_cycle", done_cyc[1], 11);
`endif

    // Endpoint never ready for 50 cycles: first command held.
    repeat (2) step(1'b1, 1'b1, 1'b1);
    repeat (51) step(1'b0, 1'b0, 1'b0);
    chk(0, "c_hold_done",   int'(dn[0]),  0);
    chk(0, "c_hold_freeze", int'(frz[0]), 1);
    chk(0, "c_hold_addr",   int'(adr[0]), 0);
    chk(0, "c_hold_data",   int'(dat[0]), 1);
    repeat (45) step(1'b0, 1'b1, 1'b1);

    // Reset mid-sequence at cycle 7 for two cycles, then full restart.
    repeat (2) step(1'b1, 1'b0, 1'b0);
    for (int j = 0; j <= 6; j++) step(1'b0, 1'b1, 1'b1);
    repeat (2) step(1'b1, 1'b1, 1'b1);
    repeat (30) step(1'b0, 1'b1, 1'b1);
`ifndef BP_CFG_LOADER_READBACK_EN
    chk(0, "d_restart_done_cycle", done_cyc[0], 21);
`endif

    // Random ready, one run with an extra mid-sequence reset.
    for (int it = 0; it < 4; it++) begin
      repeat (2) step(1'b1, 1'($urandom), 1'($urandom));
      for (int j = 0; j < 150; j++)
        step((it == 3) && (j == 40), $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/bp_cfg_loader.md
Name: bp_cfg_loader

Overview:
- Boot-time configuration sequencer sitting directly downstream of the processor parameter selection.
- Consumes the selected configuration's core count (cc_x_dim*cc_y_dim) and mode fields, then issues the per-core config-bus write sequence.
- The sequence freezes every core, programs its ID and cache/CCE modes, then unfreezes it.
- Sits at the top level between the parameter package and the tiles' config-bus endpoints; done_o gates host traffic.

Parameters:
- num_core_p, 1, number of cores; set to cc_x_dim*cc_y_dim of the selected configuration; legal range 1..16.
- cfg_addr_width_p, 8, config-bus register address width.
- cfg_data_width_p, 16, config-bus data width.
- cce_mode_p, 0, value written to each core's CCE mode register (0 = uncached, 1 = normal).
- icache_mode_p, 0, value written to each core's icache mode register.

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  synchronous active-high reset.
- cfg_v_o  out  1  config command valid.
- cfg_w_o  out  1  1 = write, 0 = read.
- cfg_core_o  out  clog2(num_core_p) (min 1)  destination core index.
- cfg_addr_o  out  cfg_addr_width_p  register address.
- cfg_data_o  out  cfg_data_width_p  write data.
- cfg_ready_i  in  1  endpoint accepts the command this cycle.
- freeze_o  out  1  high from reset until the last unfreeze write is accepted.
- done_o  out  1  sequence complete; sticky until reset.

Behaviour:
- Register addresses (package enum):
  - e_cfg_freeze = 0
  - e_cfg_core_id = 1
  - e_cfg_cce_mode = 2
  - e_cfg_icache_mode = 3
- FSM states and transitions:
  - e_reset: entered while reset_i is high. Moves to e_freeze in the first cycle reset_i is low.
  - e_freeze: for core c = 0..N-1, write addr 0, data 1.
  - e_program: for each core c in ascending order, write addr 1 data c, then addr 2 data cce_mode_p, then addr 3 data icache_mode_p.
  - e_unfreeze: for core c = 0..N-1, write addr 0, data 0.
  - e_done: terminal.
- Total writes per sequence: 5*num_core_p.
- Handshake:
  - A command retires only when cfg_v_o & cfg_ready_i.
  - While cfg_v_o is high and cfg_ready_i is low, cfg_core_o, cfg_addr_o, cfg_data_o and cfg_w_o hold stable.
  - cfg_v_o never drops without a handshake.
- cfg_v_o is combinationally high in e_freeze, e_program and e_unfreeze. No bubble is inserted between commands.
- Counters:
  - core counter, width clog2(num_core_p)+1.
  - register counter, 2 bits.
  - Both advance only on handshake and wrap to 0 at phase end.
  - Phase transition occurs on the handshake of the last command of the phase.
- Latency with cfg_ready_i tied high:
  - the first command is presented in cycle 1 after reset deasserts;
  - the last handshake occurs in cycle 5*N;
  - done_o rises in cycle 5*N+1, and freeze_o falls in the same cycle.
- Reset values:
  - cfg_v_o = 0, cfg_w_o = 0, cfg_core_o = 0, cfg_addr_o = 0, cfg_data_o = 0;
  - freeze_o = 1, done_o = 0.
- Reset mid-sequence aborts immediately: counters clear, the next cycle shows the reset values, and the full sequence restarts. No partial-state recovery.
- num_core_p = 1: cfg_core_o is 1 bit, always 0.
- cfg_ready_i in e_done or e_reset is ignored.
- Data values wider than cfg_data_width_p are truncated; the core index is zero-extended.
- cfg_w_o = 1 for all commands unless the optional feature below issues reads.

Optional Feature:
- Macro BP_CFG_LOADER_READBACK_EN.
- When defined:
  - Adds ports cfg_rdata_v_i (in, 1), cfg_rdata_i (in, cfg_data_width_p) and err_o (out, 1, reset 0).
  - After each e_program write handshake, the loader issues a read (cfg_w_o = 0) of the same core/addr, then waits in e_readback until cfg_rdata_v_i.
  - A mismatch against the written value sets err_o, which is sticky until reset. The sequence continues regardless.
  - Total commands become 8*N.
- When undefined: these ports and e_readback are absent, and behaviour is exactly as above.

Decomposition:
- Package bp_cfg_loader_pkg holds:
  - the register address enum bp_cfg_reg_e;
  - the FSM state enum bp_cfg_loader_state_e;
  - the config command struct bp_cfg_cmd_s {w, core, addr, data}.
- Sub-module bp_cfg_loader_cmd_gen: combinational, state + counters in, bp_cfg_cmd_s out.
- The FSM and counters stay in the top.

Test Plan:
- N=4, cfg_ready_i=1 -> 20 writes in cycles 1..20. Order: 4×(0,1); then core0 (1,0), (2,cce_mode_p), (3,icache_mode_p) ... core3; then 4×(0,0). done_o=1 and freeze_o=0 at cycle 21.
- N=4, cfg_ready_i toggling 1010... -> command fields stable during every stall; same 20-command order; done_o at cycle 41.
- N=1, cce_mode_p=1 -> writes (0,1),(1,0),(2,1),(3,0),(0,0) to core 0; done_o at cycle 6.
- Reset asserted at cycle 7 of an N=4 run, held 2 cycles -> outputs at reset values during reset; after release, the sequence restarts at core 0 addr 0 data 1 and completes 20 writes.
- cfg_ready_i=0 for 50 cycles after reset -> first command held unchanged; done_o stays 0, freeze_o stays 1.
- READBACK_EN, N=2, endpoint corrupts the core1 core_id read (returns 0) -> 16 commands, err_o rises the cycle after that rdata, done_o still asserts.
